// File: rtl/flash_offset_capture.sv
// flash_offset_capture: captures one resolved trim code per comparator from the
// offset finder's SAR bus on each rising edge of rdy, and serves a registered
// read port. Optional min/max code statistics are built when OFFSET_STATS_EN
// is defined; otherwise code_min/code_max are tied to zero.
module flash_offset_capture #(
  parameter int unsigned N_CMP = 32,
  parameter int unsigned BITS  = 16,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CMP-1:0] Q,
  input  logic [BITS-1:0]  DAC_ctl,
  input  logic             rdy,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [BITS-1:0]  rd_data,
  output logic             rd_valid,
  output logic [IDX_W-1:0] comp_idx,
  output logic             done,
  output logic             err,
  output logic [BITS-1:0]  code_min,
  output logic [BITS-1:0]  code_max
);

  typedef enum logic [0:0] {SWEEP, DONE} state_t;

  state_t             state_q, state_d;
  logic               rdy_q, rdy_d;
  logic [IDX_W-1:0]   comp_idx_q, comp_idx_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [N_CMP-1:0]   valid_q, valid_d;
  logic [BITS-1:0]    rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [BITS-1:0]    mem_q [N_CMP];

  logic               cap_c;
  logic               accept_c;
  logic               mem_we_c;
  logic               addr_ok_c;
  logic [BITS-1:0]    code_c;

  // Strobe edge detect and final LSB decision from the addressed comparator.
  assign cap_c     = rdy & ~rdy_q;
  assign accept_c  = cap_c & ~clr & (state_q == SWEEP);
  assign code_c    = {DAC_ctl[BITS-1:1], DAC_ctl[0] & ~Q[comp_idx_q]};
  assign addr_ok_c = (32'(rd_addr) < N_CMP);

  // Next-state: sweep control, valid bitmap, sticky error and read port.
  always_comb begin
    state_d    = state_q;
    rdy_d      = rdy;
    comp_idx_d = comp_idx_q;
    done_d     = done_q;
    err_d      = err_q;
    valid_d    = valid_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    mem_we_c   = 1'b0;

    if (clr) begin
      state_d    = SWEEP;
      comp_idx_d = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      valid_d    = '0;
    end else if (cap_c) begin
      case (state_q)
        SWEEP: begin
          mem_we_c            = 1'b1;
          valid_d[comp_idx_q] = 1'b1;
          if (comp_idx_q == IDX_W'(N_CMP - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            comp_idx_d = comp_idx_q + IDX_W'(1);
          end
        end
        DONE:    err_d = 1'b1;
        default: state_d = SWEEP;
      endcase
    end

    // Read sees pre-capture contents since it uses the current registers.
    if (rd_en) begin
      rd_valid_d = addr_ok_c & valid_q[rd_addr];
      rd_data_d  = rd_valid_d ? mem_q[rd_addr] : '0;
    end
  end

  // Control and read-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SWEEP;
      rdy_q      <= 1'b0;
      comp_idx_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      comp_idx_q <= comp_idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Code storage; unreset, qualified by the valid bitmap.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[comp_idx_q] <= code_c;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign comp_idx = comp_idx_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef OFFSET_STATS_EN
  logic [BITS-1:0] min_q, min_d, max_q, max_d;
  logic [BITS-1:0] code_min_q, code_min_d, code_max_q, code_max_d;

  // Running min/max of accepted codes; outputs stay 0 until the first capture.
  always_comb begin
    min_d      = min_q;
    max_d      = max_q;
    code_min_d = code_min_q;
    code_max_d = code_max_q;
    if (clr) begin
      min_d      = '1;
      max_d      = '0;
      code_min_d = '0;
      code_max_d = '0;
    end else if (accept_c) begin
      min_d      = (code_c < min_q) ? code_c : min_q;
      max_d      = (code_c > max_q) ? code_c : max_q;
      code_min_d = min_d;
      code_max_d = max_d;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q      <= '1;
      max_q      <= '0;
      code_min_q <= '0;
      code_max_q <= '0;
    end else begin
      min_q      <= min_d;
      max_q      <= max_d;
      code_min_q <= code_min_d;
      code_max_q <= code_max_d;
    end
  end

  assign code_min = code_min_q;
  assign code_max = code_max_q;
`else
  assign code_min = '0;
  assign code_max = '0;
`endif

endmodule

// File: tb/tb_flash_offset_capture.sv
// Testbench for flash_offset_capture: directed scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_flash_offset_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Q;
  logic [15:0] DAC_ctl;
  logic        rdy, clr, rd_en;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [4:0]  comp_idx;
  logic        done, err;
  logic [15:0] code_min, code_max;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0] m_mem [32];
  logic        m_valid [32];
  int          m_idx;
  logic        m_done, m_err, m_prev, m_any;
  logic [15:0] m_min, m_max, m_rd;
  logic        m_rv;

  always #5 clk = ~clk;

  flash_offset_capture dut (
    .clk(clk), .rst(rst), .Q(Q), .DAC_ctl(DAC_ctl), .rdy(rdy), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .comp_idx(comp_idx), .done(done), .err(err),
    .code_min(code_min), .code_max(code_max)
  );

  task automatic model_reset();
    m_idx = 0; m_done = 0; m_err = 0; m_prev = 0; m_any = 0;
    m_min = 16'h0; m_max = 16'h0; m_rd = 16'h0; m_rv = 0;
    for (int i = 0; i < 32; i++) m_valid[i] = 0;
  endtask

  task automatic model_step();
    logic        cap;
    logic [15:0] code;
    if (rd_en) begin
      m_rv = m_valid[rd_addr];
      m_rd = m_rv ? m_mem[rd_addr] : 16'h0;
    end
    cap = rdy && !m_prev;
    if (clr) begin
      m_idx = 0; m_done = 0; m_err = 0; m_any = 0; m_min = 16'h0; m_max = 16'h0;
      for (int i = 0; i < 32; i++) m_valid[i] = 0;
    end else if (cap) begin
      if (m_done) m_err = 1;
      else begin
        code = {DAC_ctl[15:1], DAC_ctl[0] & ~Q[m_idx]};
        m_mem[m_idx] = code;
        m_valid[m_idx] = 1;
        if (!m_any) begin m_min = code; m_max = code; end
        else begin
          if (code < m_min) m_min = code;
          if (code > m_max) m_max = code;
        end
        m_any = 1;
        if (m_idx == 31) m_done = 1; else m_idx++;
      end
    end
    m_prev = rdy;
  endtask

  // One clock: drive on negedge, model on posedge, leave time at posedge+1.
  task automatic tick(input logic r, input logic c, input logic re,
                      input logic [4:0] a, input logic [15:0] d, input logic [31:0] q);
    @(negedge clk);
    rdy = r; clr = c; rd_en = re; rd_addr = a; DAC_ctl = d; Q = q;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input logic [15:0] d, input logic [31:0] q);
    tick(1, 0, 0, 5'd0, d, q);
    tick(0, 0, 0, 5'd0, d, q);
  endtask

  task automatic test_reset();
    rst = 1; rdy = 0; clr = 0; rd_en = 0; rd_addr = 0; DAC_ctl = 0; Q = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (comp_idx !== 5'd0 || done !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: idx=%0d done=%b err=%b, want 0/0/0", comp_idx, done, err); end
    n_cmp++; if (rd_data !== 16'h0 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_rd: data=%h valid=%b, want 0/0", rd_data, rd_valid); end
    n_cmp++; if (code_min !== 16'h0 || code_max !== 16'h0) begin
      n_bad++; $display("FAIL reset_stats: min=%h max=%h, want 0/0", code_min, code_max); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_lsb();
    pulse(16'h8001, 32'h1);
    pulse(16'h8001, 32'h0);
    n_cmp++; if (comp_idx !== 5'd2) begin
      n_bad++; $display("FAIL lsb_idx: got %0d want 2", comp_idx); end
    tick(0, 0, 1, 5'd0, 16'h0, 32'h0);
    n_cmp++; if (rd_data !== 16'h8000 || rd_valid !== 1'b1) begin
      n_bad++; $display("FAIL lsb_e0: got %h/%b want 8000/1", rd_data, rd_valid); end
    tick(0, 0, 1, 5'd1, 16'h0, 32'h0);
    n_cmp++; if (rd_data !== 16'h8001 || rd_valid !== 1'b1) begin
      n_bad++; $display("FAIL lsb_e1: got %h/%b want 8001/1", rd_data, rd_valid); end
  endtask

  task automatic test_hold();
    tick(0, 1, 0, 5'd0, 16'h0, 32'h0);
    repeat (3) tick(1, 0, 0, 5'd0, 16'h0055, 32'h0);
    tick(0, 0, 0, 5'd0, 16'h0, 32'h0);
    n_cmp++; if (comp_idx !== 5'd1) begin
      n_bad++; $display("FAIL hold_idx: got %0d want 1", comp_idx); end
  endtask

  task automatic test_fill();
    tick(0, 1, 0, 5'd0, 16'h0, 32'h0);
    for (int i = 0; i < 32; i++) pulse(16'h1000 + 16'(i), 32'h0);
    n_cmp++; if (done !== 1'b1 || comp_idx !== 5'd31 || err !== 1'b0) begin
      n_bad++; $display("FAIL fill_done: done=%b idx=%0d err=%b want 1/31/0", done, comp_idx, err); end
    tick(0, 0, 1, 5'd31, 16'h0, 32'h0);
    n_cmp++; if (rd_data !== 16'h101F || rd_valid !== 1'b1) begin
      n_bad++; $display("FAIL fill_e31: got %h/%b want 101f/1", rd_data, rd_valid); end
    pulse(16'hBEEF, 32'h0);
    n_cmp++; if (err !== 1'b1 || done !== 1'b1 || comp_idx !== 5'd31) begin
      n_bad++; $display("FAIL fill_err: err=%b done=%b idx=%0d want 1/1/31", err, done, comp_idx); end
    tick(0, 0, 1, 5'd31, 16'h0, 32'h0);
    n_cmp++; if (rd_data !== 16'h101F) begin
      n_bad++; $display("FAIL fill_keep: got %h want 101f", rd_data); end
  endtask

  task automatic test_clr_cap();
    tick(1, 1, 0, 5'd0, 16'h7777, 32'h0);
    tick(0, 0, 0, 5'd0, 16'h0, 32'h0);
    n_cmp++; if (comp_idx !== 5'd0 || done !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL clrcap_ctrl: idx=%0d done=%b err=%b want 0/0/0", comp_idx, done, err); end
    tick(0, 0, 1, 5'd0, 16'h0, 32'h0);
    n_cmp++; if (rd_data !== 16'h0 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL clrcap_e0: got %h/%b want 0/0", rd_data, rd_valid); end
  endtask

  task automatic test_same_entry();
    tick(1, 0, 1, 5'd0, 16'h1234, 32'h0);
    n_cmp++; if (rd_data !== 16'h0 || rd_valid !== 1'b0 || comp_idx !== 5'd1) begin
      n_bad++; $display("FAIL same_old: got %h/%b idx=%0d want 0/0/1", rd_data, rd_valid, comp_idx); end
    tick(0, 0, 1, 5'd0, 16'h0, 32'h0);
    n_cmp++; if (rd_data !== 16'h1234 || rd_valid !== 1'b1) begin
      n_bad++; $display("FAIL same_new: got %h/%b want 1234/1", rd_data, rd_valid); end
    tick(0, 0, 0, 5'd5, 16'h0, 32'h0);
    n_cmp++; if (rd_data !== 16'h1234 || rd_valid !== 1'b1) begin
      n_bad++; $display("FAIL rd_hold: got %h/%b want 1234/1", rd_data, rd_valid); end
  endtask

  task automatic test_stats();
    logic [15:0] emin, emax;
    tick(0, 1, 0, 5'd0, 16'h0, 32'h0);
    n_cmp++; if (code_min !== 16'h0 || code_max !== 16'h0) begin
      n_bad++; $display("FAIL stats_empty: min=%h max=%h want 0/0", code_min, code_max); end
    pulse(16'h0400, 32'h0);
    pulse(16'h0100, 32'h0);
    pulse(16'h0801, 32'h0);
`ifdef OFFSET_STATS_EN
    emin = 16'h0100; emax = 16'h0801;
`else
    emin = 16'h0000; emax = 16'h0000;
`endif
    n_cmp++; if (code_min !== emin || code_max !== emax) begin
      n_bad++; $display("FAIL stats: min=%h max=%h want %h/%h", code_min, code_max, emin, emax); end
  endtask

  task automatic test_rst_mid();
    tick(0, 1, 0, 5'd0, 16'h0, 32'h0);
    for (int i = 0; i < 7; i++) pulse(16'h2000 + 16'(i), 32'h0);
    tick(0, 0, 1, 5'd3, 16'h0, 32'h0);
    n_cmp++; if (comp_idx !== 5'd7 || rd_valid !== 1'b1 || rd_data !== 16'h2003) begin
      n_bad++; $display("FAIL mid_pre: idx=%0d rv=%b rd=%h want 7/1/2003", comp_idx, rd_valid, rd_data); end
    @(negedge clk); rst = 1; rd_en = 0;
    #1;
    model_reset();
    n_cmp++; if (comp_idx !== 5'd0 || done !== 1'b0 || err !== 1'b0 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst: idx=%0d done=%b err=%b rv=%b want 0/0/0/0", comp_idx, done, err, rd_valid); end
    @(negedge clk); rst = 0;
    tick(0, 0, 1, 5'd3, 16'h0, 32'h0);
    n_cmp++; if (rd_data !== 16'h0 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_e3: got %h/%b want 0/0", rd_data, rd_valid); end
  endtask

  task automatic test_random();
    logic [15:0] emin, emax;
    for (int n = 0; n < 600; n++) begin
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           5'($urandom), 16'($urandom), $urandom);
      emin = 16'h0; emax = 16'h0;
`ifdef OFFSET_STATS_EN
      emin = m_any ? m_min : 16'h0;
      emax = m_any ? m_max : 16'h0;
`endif
      n_cmp++; if (comp_idx !== 5'(m_idx) || done !== m_done || err !== m_err) begin
        n_bad++; $display("FAIL rnd_ctrl@%0d: idx=%0d done=%b err=%b want %0d/%b/%b",
                          n, comp_idx, done, err, m_idx, m_done, m_err); end
      n_cmp++; if (rd_data !== m_rd || rd_valid !== m_rv) begin
        n_bad++; $display("FAIL rnd_rd@%0d: got %h/%b want %h/%b", n, rd_data, rd_valid, m_rd, m_rv); end
      n_cmp++; if (code_min !== emin || code_max !== emax) begin
        n_bad++; $display("FAIL rnd_stats@%0d: got %h/%h want %h/%h", n, code_min, code_max, emin, emax); end
    end
  endtask

  initial begin
    test_reset();
    test_lsb();
    test_hold();
    test_fill();
    test_clr_cap();
    test_same_entry();
    test_stats();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
